// File: rtl/operand_capture_e1.sv
// D/E1 operand capture: selects forwarded operands, interlocks on load-use hazards
// that forwarding cannot yet cover, and counts stall cycles with saturation.
module operand_capture_e1 #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_D,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [1:0]      ForwardA_E1,
  input  logic [1:0]      ForwardB_E1,
  input  logic [XLEN-1:0] ALUResultE2,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic            MemReadE2,
  input  logic            MemReadM,
  input  logic            FlushE1,
  output logic [XLEN-1:0] SrcA_E1,
  output logic [XLEN-1:0] SrcB_E1,
  output logic [4:0]      Rs1_E1,
  output logic [4:0]      Rs2_E1,
  output logic            valid_E1,
  output logic            StallD,
  output logic            interlock,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic {RUN, INTERLOCK} state_t;

  state_t          state_p1, state_nxt_p0;
  logic [XLEN-1:0] src_a_p0, src_b_p0;
  logic            haz_p0;

  function automatic logic [XLEN-1:0] sel_operand(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] w,
    input logic [XLEN-1:0] m,
    input logic [XLEN-1:0] e2
  );
    case (sel)
      2'b01:   return w;
      2'b10:   return m;
      2'b11:   return e2;
      default: return rf;
    endcase
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + CNTW'(1);
  endfunction

  // A forward from a load still in E2 or M carries no data yet
  function automatic logic load_pending(input logic [1:0] sel,
                                        input logic mr_e2, input logic mr_m);
    return ((sel == 2'b11) && mr_e2) || ((sel == 2'b10) && mr_m);
  endfunction

  // Stage D: operand select and hazard detection
  always_comb begin
    src_a_p0 = sel_operand(ForwardA_E1, RD1_D, ResultW, ALUResultM, ALUResultE2);
    src_b_p0 = sel_operand(ForwardB_E1, RD2_D, ResultW, ALUResultM, ALUResultE2);
    haz_p0   = valid_D && !FlushE1 &&
               (load_pending(ForwardA_E1, MemReadE2, MemReadM) ||
                load_pending(ForwardB_E1, MemReadE2, MemReadM));
  end

  assign StallD = haz_p0 && rst;

  // Stage D/E1 boundary register
  always_ff @(posedge clk) begin
    if (!rst) begin
      SrcA_E1   <= '0;
      SrcB_E1   <= '0;
      Rs1_E1    <= '0;
      Rs2_E1    <= '0;
      valid_E1  <= 1'b0;
      stall_cnt <= '0;
    end else if (haz_p0) begin
      valid_E1  <= 1'b0;
      stall_cnt <= sat_inc(stall_cnt);
    end else begin
      SrcA_E1   <= src_a_p0;
      SrcB_E1   <= src_b_p0;
      Rs1_E1    <= Rs1_D;
      Rs2_E1    <= Rs2_D;
      valid_E1  <= valid_D && !FlushE1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_p1 <= RUN;
    else      state_p1 <= state_nxt_p0;
  end

  always_comb begin
    state_nxt_p0 = state_p1;
    case (state_p1)
      RUN:       if (haz_p0)  state_nxt_p0 = INTERLOCK;
      INTERLOCK: if (!haz_p0) state_nxt_p0 = RUN;
      default:   state_nxt_p0 = RUN;
    endcase
  end

  always_comb begin
    interlock = (state_p1 == INTERLOCK);
  end

endmodule

// File: tb/tb_operand_capture_e1.sv
// Scoreboard bench for operand_capture_e1: stimulus pushes expected E1 contents,
// a negedge monitor pops and compares whenever valid_E1 is high.
module tb_operand_capture_e1;

  localparam int XLEN = 32;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_D;
  logic [4:0]      Rs1_D, Rs2_D;
  logic [XLEN-1:0] RD1_D, RD2_D;
  logic [1:0]      ForwardA_E1, ForwardB_E1;
  logic [XLEN-1:0] ALUResultE2, ALUResultM, ResultW;
  logic            MemReadE2, MemReadM, FlushE1;
  logic [XLEN-1:0] SrcA_E1, SrcB_E1;
  logic [4:0]      Rs1_E1, Rs2_E1;
  logic            valid_E1, StallD, interlock;
  logic [CNTW-1:0] stall_cnt;

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      r1;
    logic [4:0]      r2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  operand_capture_e1 #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ForwardA_E1(ForwardA_E1), .ForwardB_E1(ForwardB_E1),
    .ALUResultE2(ALUResultE2), .ALUResultM(ALUResultM), .ResultW(ResultW),
    .MemReadE2(MemReadE2), .MemReadM(MemReadM), .FlushE1(FlushE1),
    .SrcA_E1(SrcA_E1), .SrcB_E1(SrcB_E1), .Rs1_E1(Rs1_E1), .Rs2_E1(Rs2_E1),
    .valid_E1(valid_E1), .StallD(StallD), .interlock(interlock), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_E1 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_E1", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("SrcA_E1", SrcA_E1, e.a);
        chk("SrcB_E1", SrcB_E1, e.b);
        chk("Rs1_E1",  Rs1_E1,  e.r1);
        chk("Rs2_E1",  Rs2_E1,  e.r2);
      end
    end
  end

  // Inputs already set; check StallD, enqueue expected result, advance one edge.
  task automatic cycle(input string nm, input logic exp_stall,
                       input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
    #1;
    chk({nm, "_StallD"}, StallD, exp_stall);
    if (!exp_stall && valid_D && !FlushE1 && rst)
      sb.push_back('{ea, eb, Rs1_D, Rs2_D});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_haz();
    MemReadE2 = 1'b0; MemReadM = 1'b0; FlushE1 = 1'b0;
    ForwardA_E1 = 2'b00; ForwardB_E1 = 2'b00;
  endtask

  initial begin
    rst = 1'b0; valid_D = 1'b1; Rs1_D = 5'd1; Rs2_D = 5'd2;
    RD1_D = 32'h1234; RD2_D = 32'h55;
    ALUResultE2 = '0; ALUResultM = '0; ResultW = '0;
    clear_haz();

    // Reset held two cycles, hazard present in the second
    @(posedge clk); #1;
    ForwardA_E1 = 2'b11; MemReadE2 = 1'b1;
    cycle("rst", 1'b0, '0, '0);
    chk("rst_SrcA", SrcA_E1, 0);
    chk("rst_SrcB", SrcB_E1, 0);
    chk("rst_Rs1", Rs1_E1, 0);
    chk("rst_valid", valid_E1, 0);
    chk("rst_interlock", interlock, 0);
    chk("rst_cnt", stall_cnt, 0);

    rst = 1'b1; clear_haz();
    cycle("release", 1'b0, 32'h1234, 32'h55);

    // Forward-select patterns
    ForwardA_E1 = 2'b11; ForwardB_E1 = 2'b10; Rs1_D = 5'd3; Rs2_D = 5'd4;
    ALUResultE2 = 32'hAAAA0001; ALUResultM = 32'h5555000F; ResultW = 32'hDEADBEEF;
    cycle("sel_e2_m", 1'b0, 32'hAAAA0001, 32'h5555000F);
    ForwardA_E1 = 2'b01; ForwardB_E1 = 2'b01;
    cycle("sel_w", 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    ForwardA_E1 = 2'b00; ForwardB_E1 = 2'b00; RD1_D = 32'h0BAD; RD2_D = 32'hF00D;
    cycle("sel_rf", 1'b0, 32'h0BAD, 32'hF00D);
    ForwardA_E1 = 2'b10; ForwardB_E1 = 2'b11; Rs1_D = 5'd31; Rs2_D = 5'd17;
    cycle("sel_m_e2", 1'b0, 32'h5555000F, 32'hAAAA0001);
    chk("sel_cnt", stall_cnt, 0);

    // Load-use with the load in E2: two stall cycles then forward from W
    Rs1_D = 5'd5; Rs2_D = 5'd6; ForwardB_E1 = 2'b00; RD2_D = 32'h66;
    ForwardA_E1 = 2'b11; MemReadE2 = 1'b1;
    #1 chk("lu_n_interlock", interlock, 0);
    cycle("lu_n", 1'b1, '0, '0);
    chk("lu_n_bubble", valid_E1, 0);
    chk("lu_n_cnt", stall_cnt, 1);
    ForwardA_E1 = 2'b10; MemReadE2 = 1'b0; MemReadM = 1'b1;
    chk("lu_n1_interlock", interlock, 1);
    cycle("lu_n1", 1'b1, '0, '0);
    chk("lu_n1_bubble", valid_E1, 0);
    chk("lu_n1_cnt", stall_cnt, 2);
    ForwardA_E1 = 2'b01; MemReadM = 1'b0; ResultW = 32'h77;
    chk("lu_n2_interlock", interlock, 1);
    cycle("lu_n2", 1'b0, 32'h77, 32'h66);
    chk("lu_done_interlock", interlock, 0);
    chk("lu_done_cnt", stall_cnt, 2);

    // Flush overrides a hazard
    ForwardA_E1 = 2'b11; MemReadE2 = 1'b1; FlushE1 = 1'b1;
    cycle("flush", 1'b0, '0, '0);
    chk("flush_valid", valid_E1, 0);
    chk("flush_cnt", stall_cnt, 2);
    chk("flush_interlock", interlock, 0);

    // Reset during an interlock drops it at once
    FlushE1 = 1'b0;
    cycle("mid_stall", 1'b1, '0, '0);
    chk("mid_interlock", interlock, 1);
    chk("mid_cnt", stall_cnt, 3);
    rst = 1'b0;
    cycle("mid_rst", 1'b0, '0, '0);
    chk("mid_rst_interlock", interlock, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    chk("mid_rst_valid", valid_E1, 0);

    // Counter saturates at all-ones
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle("sat", 1'b1, '0, '0);
      chk("sat_cnt", stall_cnt, (i + 1 > 15) ? 15 : i + 1);
      chk("sat_bubble", valid_E1, 0);
    end
    clear_haz(); RD1_D = 32'hCAFE0000; RD2_D = 32'h0000BEEF;
    cycle("sat_exit", 1'b0, 32'hCAFE0000, 32'h0000BEEF);
    chk("sat_hold_cnt", stall_cnt, 15);
    chk("sat_exit_interlock", interlock, 0);

    valid_D = 1'b0;
    cycle("idle", 1'b0, '0, '0);
    cycle("idle", 1'b0, '0, '0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/operand_capture_e1.md
Name: operand_capture_e1

Overview:
- Consumer end of the E1 forwarding interface in the 6-stage pipeline (D, E1, E2, M, W).
- Takes the 2-bit ForwardA_E1/ForwardB_E1 selects and picks each source operand from the register file, E2, M or W.
- Detects load-use cases that forwarding cannot resolve. Freezes D and injects E1 bubbles until the data is forwardable.
- Registers the selected operands into the D/E1 boundary and keeps a stall-cycle performance counter.

Parameters:
- XLEN, 32, datapath/operand width.
- CNTW, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_D  in  1  D holds a valid instruction.
- Rs1_D  in  5  source register index 1 of the instruction in D.
- Rs2_D  in  5  source register index 2 of the instruction in D.
- RD1_D  in  XLEN  register-file read data, port 1.
- RD2_D  in  XLEN  register-file read data, port 2.
- ForwardA_E1  in  2  operand-A select: 00 regfile, 01 W, 10 M, 11 E2.
- ForwardB_E1  in  2  operand-B select, same encoding.
- ALUResultE2  in  XLEN  result currently in E2.
- ALUResultM  in  XLEN  ALU result currently in M.
- ResultW  in  XLEN  final writeback value in W.
- MemReadE2  in  1  instruction in E2 is a load (its data is not yet available).
- MemReadM  in  1  instruction in M is a load (data available only from W).
- FlushE1  in  1  branch/exception kill of the instruction in D.
- SrcA_E1  out  XLEN  registered operand A.
- SrcB_E1  out  XLEN  registered operand B.
- Rs1_E1  out  5  registered Rs1.
- Rs2_E1  out  5  registered Rs2.
- valid_E1  out  1  E1 holds a valid instruction.
- StallD  out  1  combinational; hold the PC and the F/D register.
- interlock  out  1  registered; FSM is in INTERLOCK.
- stall_cnt  out  CNTW  saturating count of stall cycles.

Behaviour:
- Reset (rst==0 at a clk edge):
  - SrcA_E1, SrcB_E1, Rs1_E1, Rs2_E1 = 0.
  - valid_E1 = 0, interlock = 0, stall_cnt = 0, FSM = RUN.
  - StallD = 0 while rst==0.
  - A reset mid-interlock drops the pending stall immediately.
- Operand select (combinational), per operand:
  - 00 selects RDx_D, 01 ResultW, 10 ALUResultM, 11 ALUResultE2.
  - Full XLEN width; no sign or zero manipulation.
- Hazard condition haz: valid_D && !FlushE1 && any of the following, for either operand X:
  - ForwardX==11 && MemReadE2
  - ForwardX==10 && MemReadM
- Hazard evaluation:
  - haz is re-evaluated every cycle. The forward selects change as the load advances, so no fixed stall length is latched.
  - StallD = haz.
  - A load in E2 therefore costs 2 stall cycles; a load in M costs 1.
- Normal cycle (haz==0), registers load:
  - SrcA_E1 and SrcB_E1 take the selected operands.
  - Rs1_E1 and Rs2_E1 take Rs1_D and Rs2_D.
  - valid_E1 = valid_D && !FlushE1.
- Stall cycle (haz==1):
  - valid_E1 = 0 (bubble). SrcA_E1, SrcB_E1, Rs1_E1 and Rs2_E1 hold their previous values.
  - stall_cnt += 1, saturating at all-ones with no wrap.
- FlushE1:
  - FlushE1 overrides haz: no stall, and valid_E1 loads 0.
  - Operand registers may load, but their value is don't-care.
- FSM (2 states):
  - RUN -> INTERLOCK when haz.
  - INTERLOCK -> RUN when !haz.
  - Otherwise stay.
  - interlock output = (state==INTERLOCK); it lags haz by one cycle.
- Forwarding from regfile on a same-cycle W write: the regfile is write-first, so select 00 is correct. This block does no bypass of its own.
- Rs == x0: the forward select is 00 by construction, so RD returns 0 and no hazard is possible.
- Latency: D to E1 is 1 cycle. Operands are valid in the cycle valid_E1==1.

Test Plan:
- Reset: hold rst=0 for 2 cycles with valid_D=1 and RD1_D=0x1234 -> all outputs 0, StallD=0. Release -> next edge SrcA_E1=0x1234, valid_E1=1.
- Selects: ForwardA=11, ForwardB=10, ALUResultE2=0xAAAA0001, ALUResultM=0x5555000F, no loads -> SrcA_E1=0xAAAA0001, SrcB_E1=0x5555000F, no stall. Repeat with 01 (ResultW=0xDEADBEEF) and 00.
- Load-use, load in E2: cycle n ForwardA=11 with MemReadE2=1; n+1 ForwardA=10 with MemReadM=1; n+2 ForwardA=01 with ResultW=0x77 -> StallD=1 at n and n+1, bubbles into E1, SrcA_E1=0x77 and valid_E1=1 after n+2, stall_cnt=2, interlock high for 2 cycles.
- Flush priority: haz conditions present with FlushE1=1 -> StallD=0, valid_E1=0, stall_cnt unchanged.
- Mid-interlock reset: assert rst=0 during the first stall cycle -> next edge interlock=0, stall_cnt=0, valid_E1=0.
- Saturation: with CNTW=4, drive 20 consecutive stall cycles -> stall_cnt stops at 15.
